// File: rtl/usr_tx_ctrl_if.sv
// Word-input handshake for usr_tx_ctrl: a 4-bit word plus its shift direction.
interface usr_tx_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       msb_first;

   modport master (output in_valid, in_data, msb_first, input in_ready);
   modport slave  (input in_valid, in_data, msb_first, output in_ready);
endinterface

// File: rtl/usr_tx_ctrl.sv
// Serialises 4-bit words through an external 4-bit universal shift register:
// one load cycle, four shift cycles, then an optional idle gap.
module usr_tx_ctrl #(
   parameter logic FILL_BIT   = 1'b0,
   parameter int   GAP_CYCLES = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   usr_tx_ctrl_if.slave in_if,
   output logic         s1,
   output logic         s0,
   output logic         sr,
   output logic         sl,
   output logic [3:0]   pdin,
   input  logic [3:0]   pdout,
   output logic         sdo,
   output logic         sdo_valid,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t     state;
   logic [1:0] cnt;
   logic [3:0] gcnt;
   logic       dir;
   logic       rdy_q;

   assign in_if.in_ready = rdy_q;

   // sdo_valid is only set in SHIFT, so it doubles as the gate that forces sdo low elsewhere.
   assign sdo = sdo_valid & (dir ? pdout[3] : pdout[0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         gcnt      <= 4'd0;
         pdin      <= 4'd0;
         dir       <= 1'b0;
         rdy_q     <= 1'b1;
         s1        <= 1'b0;
         s0        <= 1'b0;
         sr        <= 1'b0;
         sl        <= 1'b0;
         sdo_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_if.in_valid && rdy_q) begin
                  pdin      <= in_if.in_data;
                  dir       <= in_if.msb_first;
                  rdy_q     <= 1'b0;
                  {s1, s0}  <= 2'b11;
                  state     <= LOAD;
               end
            end

            LOAD: begin
               cnt       <= 2'd0;
               {s1, s0}  <= dir ? 2'b10 : 2'b01;
               sr        <= FILL_BIT;
               sl        <= FILL_BIT;
               sdo_valid <= 1'b1;
               done      <= 1'b0;
               state     <= SHIFT;
            end

            SHIFT: begin
               cnt  <= cnt + 2'd1;
               done <= (cnt == 2'd2);
               if (cnt == 2'd3) begin
                  {s1, s0}  <= 2'b00;
                  sr        <= 1'b0;
                  sl        <= 1'b0;
                  sdo_valid <= 1'b0;
                  done      <= 1'b0;
                  gcnt      <= 4'd0;
                  if (GAP_CYCLES > 0) begin
                     state <= GAP;
                  end else begin
                     rdy_q <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            GAP: begin
               if (gcnt == GAP_LAST) begin
                  gcnt  <= 4'd0;
                  rdy_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + 4'd1;
               end
            end

            default: begin
               rdy_q <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usr_tx_ctrl.sv
// Three controllers (plain, 2-cycle gap, fill=1) each paired with a behavioural
// shift register; a scoreboard queue holds the expected serial bits.
module tb_usr_tx_ctrl;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]      iv, msb, rdy, s1, s0, sr, sl, sdo, sv, dn;
   logic [N-1:0][3:0] id, pdin, pdout;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int inst; logic b; logic last; logic dir;} exp_t;
   exp_t sbq[$];

   int n_chk = 0, n_pass = 0, n_fail = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      usr_tx_ctrl_if ifc();
      logic [3:0] q;

      assign ifc.in_valid  = iv[g];
      assign ifc.in_data   = id[g];
      assign ifc.msb_first = msb[g];
      assign rdy[g]        = ifc.in_ready;
      assign pdout[g]      = q;

      usr_tx_ctrl #(.FILL_BIT(g == 2 ? 1'b1 : 1'b0), .GAP_CYCLES(g == 1 ? 2 : 0)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_if(ifc),
         .s1(s1[g]), .s0(s0[g]), .sr(sr[g]), .sl(sl[g]),
         .pdin(pdin[g]), .pdout(pdout[g]),
         .sdo(sdo[g]), .sdo_valid(sv[g]), .done(dn[g])
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) q <= 4'd0;
         else case ({s1[g], s0[g]})
            2'b01:   q <= {sr[g], q[3:1]};
            2'b10:   q <= {q[2:0], sl[g]};
            2'b11:   q <= pdin[g];
            default: q <= q;
         endcase
      end
   end

   task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, g, obs, exp);
      end
   endtask

   // Serial monitor: every payload bit must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int g = 0; g < N; g++) begin
         if (sv[g] === 1'b1) begin
            if (sbq.size() > 0) e = sbq.pop_front();
            else begin e.inst = -1; e.b = 1'b0; e.last = 1'b0; e.dir = 1'b0; end
            check("sb_inst", g, g, e.inst);
            check("sdo", g, sdo[g], e.b);
            check("done", g, dn[g], e.last);
            check("mode", g, {s1[g], s0[g]}, e.dir ? 2 : 1);
            check("fill", g, {sr[g], sl[g]}, (g == 2) ? 3 : 0);
         end else begin
            check("idle_out", g, {dn[g], sdo[g], sr[g], sl[g]}, 0);
         end
      end
   end

   task automatic check_rst(input string tag);
      for (int g = 0; g < N; g++) begin
         check({tag, "_ctrl"}, g, {s1[g], s0[g], sr[g], sl[g]}, 0);
         check({tag, "_ser"},  g, {sdo[g], sv[g], dn[g]}, 0);
         check({tag, "_data"}, g, {pdin[g], pdout[g]}, 0);
      end
   endtask

   // Holds in_valid until accepted; returns one cycle after the handshake edge with in_valid still high.
   task automatic send(input int g, input logic [3:0] d, input logic m, output int hs);
      int k;
      iv[g] = 1'b1; id[g] = d; msb[g] = m;
      k = 0;
      while (rdy[g] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      check("hs_ready", g, rdy[g], 1);
      hs = cyc;
      for (int i = 0; i < 4; i++) sbq.push_back('{g, m ? d[3-i] : d[i], i == 3, m});
      @(negedge clk);
   endtask

   task automatic drain(input int g);
      int k;
      iv = '0;
      k = 0;
      while ((sbq.size() != 0 || rdy !== {N{1'b1}}) && k < 100) begin @(negedge clk); k++; end
      check("drain", g, sbq.size(), 0);
   endtask

   initial begin
      int h1, h2, k;
      iv = '0; id = '0; msb = '0;
      repeat (2) @(negedge clk);
      check_rst("reset");
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < N; g++) check("rdy_after_rst", g, rdy[g], 1);
      @(negedge clk);

      // LSB first, then MSB first
      send(0, 4'b1011, 1'b0, h1);
      drain(0);
      check("pdout_lsb_end", 0, pdout[0], 4'b0000);
      send(0, 4'b1011, 1'b1, h1);
      drain(0);

      // back-to-back with in_valid held high
      send(0, 4'b0110, 1'b0, h1);
      id[0] = 4'b1001;
      send(0, 4'b1001, 1'b0, h2);
      check("b2b_spacing", 0, h2 - h1, 6);
      drain(0);

      // two queued words through the 2-cycle gap instance
      send(1, 4'b1100, 1'b0, h1);
      id[1] = 4'b0011;
      k = 0;
      while (dn[1] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      check("gap_done_seen", 1, dn[1], 1);
      repeat (2) begin
         @(negedge clk);
         check("gap_rdy", 1, rdy[1], 0);
         check("gap_sv", 1, sv[1], 0);
      end
      @(negedge clk);
      check("gap_idle_rdy", 1, rdy[1], 1);
      send(1, 4'b0011, 1'b0, h2);
      check("gap_spacing", 1, h2 - h1, 8);
      drain(1);

      // reset during the second SHIFT cycle
      send(0, 4'b0101, 1'b1, h1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      sbq.delete();
      iv = '0;
      #1;
      check_rst("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rdy_after_mid_rst", 0, rdy[0], 1);
      send(0, 4'b1111, 1'b0, h1);
      drain(0);

      // fill bit 1 shifts ones into the register
      send(2, 4'b0000, 1'b0, h1);
      drain(2);
      check("pdout_fill", 2, pdout[2], 4'b1111);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/usr_tx_ctrl.md
USR_TX_CTRL -- requirements
Module: usr_tx_ctrl

Interface
REQ-001 Parameter FILL_BIT, default 1'b0, is the bit driven on sr/sl while shifting.
REQ-002 Parameter GAP_CYCLES, default 0, is the number of idle cycles (0..15) inserted after each word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  source has a 4-bit word to transmit.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  4  word to transmit.
REQ-008 msb_first  input  1  direction for the word, sampled at the handshake; 0 = LSB first.
REQ-009 s1, s0  output  1 each  mode to the shift register: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-010 sr, sl  output  1 each  serial fill bits to the shift register.
REQ-011 pdin  output  4  parallel load word to the shift register.
REQ-012 pdout  input  4  shift register contents.
REQ-013 sdo  output  1  serial data out.
REQ-014 sdo_valid  output  1  sdo carries a payload bit this cycle.
REQ-015 done  output  1  one-cycle pulse on the last bit of a word.

Function
REQ-016 The shift register on s1/s0/sr/sl/pdin/pdout updates as follows: right shift q <= {sr, q[3:1]}; left shift q <= {q[2:0], sl}; load q <= pdin.
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT and GAP.
REQ-018 IDLE: in_ready=1, {s1,s0}=00, sdo_valid=0.
REQ-019 Handshake occurs when in_valid && in_ready at a clock edge; in_data goes to the pdin register, msb_first to the dir register, and the state moves to LOAD.
REQ-020 in_ready SHALL be 0 in LOAD, SHIFT and GAP; in_valid is ignored there.
REQ-021 LOAD lasts exactly one cycle with {s1,s0}=11 and pdin stable; next state is SHIFT with bit counter = 0.
REQ-022 SHIFT: {s1,s0}=01 when dir=0 and 10 when dir=1; sr=sl=FILL_BIT.
REQ-023 SHIFT: sdo = pdout[0] when dir=0 and pdout[3] when dir=1, combinationally; sdo_valid=1.
REQ-024 The 2-bit counter increments on each SHIFT cycle; SHIFT lasts exactly 4 cycles.
REQ-025 done=1 only on the SHIFT cycle with counter==3.
REQ-026 After the 4th SHIFT cycle, the state goes to GAP if GAP_CYCLES>0, else to IDLE.
REQ-027 GAP: {s1,s0}=00, sdo_valid=0, sdo=0; stays for exactly GAP_CYCLES cycles, then IDLE.
REQ-028 Outside SHIFT, sdo=0 and sr=sl=0.
REQ-029 Latency: handshake at edge N -> LOAD in cycle N+1 -> payload bits in cycles N+2..N+5.
REQ-030 Throughput: at most one word per 6+GAP_CYCLES cycles.
REQ-031 pdin and dir SHALL hold their values from the handshake until the next handshake.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, counter 0, gap counter 0, pdin=0000, dir=0, {s1,s0}=00, sr=sl=0, sdo=0, sdo_valid=0, done=0.
REQ-033 Reset mid-word SHALL abandon the word with no further sdo_valid.
REQ-034 After reset, in_ready=1 from the first cycle with rst_n high.
REQ-035 The block shares rst_n with the shift register, so pdout=0000 after reset.

Verification
REQ-036 Bench SHALL pair the DUT with a behavioural shift register per REQ-016.
REQ-037 LSB first: in_data=1011, msb_first=0 -> sdo=1,1,0,1 on 4 consecutive sdo_valid cycles; done on the 4th; pdout=0000 afterwards.
REQ-038 MSB first: in_data=1011, msb_first=1 -> sdo=1,0,1,1; {s1,s0}=10 throughout SHIFT.
REQ-039 Back-to-back: in_valid held high with 0110 then 1001, GAP_CYCLES=0 -> second handshake exactly 6 cycles after the first; serial stream 0,1,1,0,1,0,0,1 (LSB first).
REQ-040 Gap: GAP_CYCLES=2, two queued words -> exactly 2 cycles with in_ready=0 and sdo_valid=0 between the last bit of word 1 and the next IDLE.
REQ-041 Reset mid-shift: assert rst_n low during the 2nd SHIFT cycle -> all outputs match REQ-032 in the same cycle; after release, in_ready=1 and a new word 1111 transmits 1,1,1,1.
REQ-042 Fill check: FILL_BIT=1, in_data=0000 -> sdo=0,0,0,0 and pdout=1111 after SHIFT.
